// File: rtl/led_pattern_scheduler.sv
// Round-robin LED blink-pattern scheduler: requester i earns i+1 blinks plus a
// dark gap, paced by a prescaled tick from the low-frequency oscillator.
module led_pattern_scheduler #(
    parameter int unsigned CLK_DIV   = 32'd33000,
    parameter int unsigned GAP_TICKS = 32'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       busy,
    output logic       done,
    output logic       led
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    localparam logic [31:0] TICK_TC  = 32'(CLK_DIV);
    localparam logic [3:0]  GAP_INIT = 4'(GAP_TICKS);

    state_e      state_q, state_d;
    logic [31:0] presc_q, presc_d;
    logic [2:0]  blink_q, blink_d;
    logic [3:0]  gap_q, gap_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [1:0]  owner_q, owner_d;
    logic [3:0]  grant_q, grant_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        led_q, led_d;
    logic        tick_s;
    logic [2:0]  pick_s;

    // Returns {found, index}; the slot just after last wins, last itself is tried last.
    function automatic logic [2:0] rr_pick(input logic [3:0] req_v, input logic [1:0] last);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req_v[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

    assign tick_s = (presc_q == TICK_TC);
    assign pick_s = rr_pick(req, last_grant_q);

    // Next-state and next-output logic for the pattern sequencer
    always_comb begin
        state_d      = state_q;
        presc_d      = tick_s ? 32'd0 : presc_q + 32'd1;
        blink_d      = blink_q;
        gap_d        = gap_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        led_d        = led_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_s[2]) begin
                    // Restart the prescaler so the first ON phase is a full tick long
                    state_d = ST_ON;
                    presc_d = 32'd0;
                    owner_d = pick_s[1:0];
                    grant_d = 4'b0001 << pick_s[1:0];
                    busy_d  = 1'b1;
                    blink_d = {1'b0, pick_s[1:0]} + 3'd1;
                    led_d   = 1'b1;
                end else begin
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                    led_d   = 1'b0;
                end
            end
            ST_ON: begin
                if (tick_s) begin
                    state_d = ST_OFF;
                    led_d   = 1'b0;
                end else begin
                    led_d   = 1'b1;
                end
            end
            ST_OFF: begin
                if (tick_s) begin
                    blink_d = blink_q - 3'd1;
                    if (blink_q != 3'd1) begin
                        state_d = ST_ON;
                        led_d   = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = GAP_INIT;
                        led_d   = 1'b0;
                    end
                end else begin
                    led_d = 1'b0;
                end
            end
            ST_GAP: begin
                led_d = 1'b0;
                if (tick_s) begin
                    gap_d = gap_q - 4'd1;
                    if (gap_q == 4'd1) begin
                        state_d      = ST_IDLE;
                        done_d       = 1'b1;
                        grant_d      = 4'b0000;
                        busy_d       = 1'b0;
                        last_grant_d = owner_q;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
                busy_d  = 1'b0;
                led_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            presc_q      <= 32'd0;
            blink_q      <= 3'd0;
            gap_q        <= 4'd0;
            last_grant_q <= 2'd3;
            owner_q      <= 2'd0;
            grant_q      <= 4'b0000;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            led_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            blink_q      <= blink_d;
            gap_q        <= gap_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            led_q        <= led_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign led   = led_q;

    led_pattern_scheduler_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .grant (grant_q),
        .busy  (busy_q),
        .done  (done_q),
        .led   (led_q)
    );

endmodule

// Output-protocol checker: ownership encoding, busy consistency, done placement.
module led_pattern_scheduler_chk (
    input logic       clk,
    input logic       rst_n,
    input logic [3:0] grant,
    input logic       busy,
    input logic       done,
    input logic       led
);

    logic prev_busy_q;

    // Sample outputs each edge; done may only follow the cycle that left GAP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_busy_q <= 1'b0;
        end else begin
            prev_busy_q <= busy;
            a_grant_onehot0: assert ($onehot0(grant));
            a_busy_is_grant: assert (busy == (grant != 4'b0000));
            a_led_off_idle:  assert (busy || !led);
            if (done) begin
                a_done_on_exit: assert (prev_busy_q && !busy);
            end
        end
    end

endmodule
